rs_custom: RTL and testbench

- Reservation station feeding the custom execution unit, which sits directly downstream.
- Holds dispatched custom-op instructions until both source operands are available.
- Captures operands from result-bus wakeup broadcasts, selects one ready entry per cycle and drives the custom unit's issue/operand inputs.
- Invalidates wrong-path entries on branch mispredict; clears speculative bits on correct prediction.

---
 rtl/rs_custom.sv | 153 +++++++++++++++
 tb/tb_rs_custom.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_custom.sv
// Reservation station for the custom execution unit. Buffers dispatched
// custom ops, captures operands from the two result buses, and issues the
// lowest-index ready entry each cycle. Wrong-path entries are killed on a
// mispredict; speculative bits are cleared on a correctly resolved branch.
module rs_custom #(
  parameter int DATA_LEN    = 32,
  parameter int RRF_SEL     = 6,
  parameter int SPECTAG_LEN = 5,
  parameter int ENT_NUM     = 4,
  parameter int ENT_SEL     = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dp_we,
  input  logic [DATA_LEN-1:0]    dp_src1,
  input  logic [DATA_LEN-1:0]    dp_src2,
  input  logic                   dp_valid1,
  input  logic                   dp_valid2,
  input  logic [DATA_LEN-1:0]    dp_imm,
  input  logic [RRF_SEL-1:0]     dp_rrftag,
  input  logic                   dp_dstval,
  input  logic [2:0]             dp_funct3,
  input  logic [6:0]             dp_funct7,
  input  logic [SPECTAG_LEN-1:0] dp_spectag,
  input  logic                   dp_specbit,
  input  logic                   wb_val0,
  input  logic                   wb_val1,
  input  logic [RRF_SEL-1:0]     wb_tag0,
  input  logic [RRF_SEL-1:0]     wb_tag1,
  input  logic [DATA_LEN-1:0]    wb_data0,
  input  logic [DATA_LEN-1:0]    wb_data1,
  input  logic                   prmiss,
  input  logic [SPECTAG_LEN-1:0] killmask,
  input  logic                   prsuccess,
  input  logic [SPECTAG_LEN-1:0] prtag,
  output logic                   full,
  output logic [ENT_SEL:0]       busy_cnt,
  output logic                   issue,
  output logic [DATA_LEN-1:0]    ex_src1,
  output logic [DATA_LEN-1:0]    ex_src2,
  output logic [DATA_LEN-1:0]    ex_imm,
  output logic [RRF_SEL-1:0]     ex_rrftag,
  output logic                   ex_dstval,
  output logic [2:0]             ex_funct3,
  output logic [6:0]             ex_funct7,
  output logic [SPECTAG_LEN-1:0] ex_spectag,
  output logic                   ex_specbit
);

  // Per-entry state. Only ent_vld is reset; the rest is qualified by it.
  logic [ENT_NUM-1:0]     ent_vld;
  logic [ENT_NUM-1:0]     ent_v1;
  logic [ENT_NUM-1:0]     ent_v2;
  logic [ENT_NUM-1:0]     ent_dstval;
  logic [ENT_NUM-1:0]     ent_specbit;
  logic [DATA_LEN-1:0]    ent_src1    [ENT_NUM];
  logic [DATA_LEN-1:0]    ent_src2    [ENT_NUM];
  logic [DATA_LEN-1:0]    ent_imm     [ENT_NUM];
  logic [RRF_SEL-1:0]     ent_rrftag  [ENT_NUM];
  logic [2:0]             ent_funct3  [ENT_NUM];
  logic [6:0]             ent_funct7  [ENT_NUM];
  logic [SPECTAG_LEN-1:0] ent_spectag [ENT_NUM];

  logic [ENT_NUM-1:0] ready;
  logic [ENT_NUM-1:0] killed;
  logic [ENT_SEL-1:0] sel;
  logic [ENT_SEL-1:0] free_idx;
  logic               any_ready;
  logic               dp_write;

  // Returns {valid, value}: a not-yet-valid operand holds its tag in the low
  // bits and picks up matching broadcast data, bus 0 taking precedence.
  function automatic logic [DATA_LEN:0] snoop(input logic vld,
                                              input logic [DATA_LEN-1:0] val);
    logic [RRF_SEL-1:0] tag;
    tag = val[RRF_SEL-1:0];
    if (vld)                         return {1'b1, val};
    if (wb_val0 && wb_tag0 == tag)   return {1'b1, wb_data0};
    if (wb_val1 && wb_tag1 == tag)   return {1'b1, wb_data1};
    return {1'b0, val};
  endfunction

  assign full     = &ent_vld;
  assign dp_write = dp_we && !full && !prmiss;

  // Ready/kill vectors, priority select, free-slot search and occupancy count.
  always_comb begin
    ready     = ent_vld & ent_v1 & ent_v2;
    killed    = '0;
    sel       = '0;
    any_ready = 1'b0;
    free_idx  = '0;
    busy_cnt  = '0;
    for (int i = ENT_NUM - 1; i >= 0; i--) begin
      killed[i] = prmiss && ent_specbit[i] && |(ent_spectag[i] & killmask);
      if (ready[i]) begin
        sel       = ENT_SEL'(i);
        any_ready = 1'b1;
      end
      if (!ent_vld[i]) free_idx = ENT_SEL'(i);
      busy_cnt = busy_cnt + (ENT_SEL+1)'(ent_vld[i]);
    end
    issue = any_ready && !killed[sel];
  end

  assign ex_src1    = ent_src1[sel];
  assign ex_src2    = ent_src2[sel];
  assign ex_imm     = ent_imm[sel];
  assign ex_rrftag  = ent_rrftag[sel];
  assign ex_dstval  = ent_dstval[sel];
  assign ex_funct3  = ent_funct3[sel];
  assign ex_funct7  = ent_funct7[sel];
  assign ex_spectag = ent_spectag[sel];
  assign ex_specbit = ent_specbit[sel];

  // Entry occupancy: kill and issue free slots, dispatch claims the lowest free one.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_vld <= '0;
    end else begin
      for (int i = 0; i < ENT_NUM; i++) begin
        if (killed[i] || (issue && sel == ENT_SEL'(i))) ent_vld[i] <= 1'b0;
      end
      if (dp_write) ent_vld[free_idx] <= 1'b1;
    end
  end

  // Entry payload: load on dispatch, otherwise capture wakeups and clear specbits.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENT_NUM; i++) begin
      if (dp_write && free_idx == ENT_SEL'(i)) begin
        {ent_v1[i], ent_src1[i]} <= snoop(dp_valid1, dp_src1);
        {ent_v2[i], ent_src2[i]} <= snoop(dp_valid2, dp_src2);
        ent_imm[i]     <= dp_imm;
        ent_rrftag[i]  <= dp_rrftag;
        ent_dstval[i]  <= dp_dstval;
        ent_funct3[i]  <= dp_funct3;
        ent_funct7[i]  <= dp_funct7;
        ent_spectag[i] <= dp_spectag;
        ent_specbit[i] <= dp_specbit && !(prsuccess && dp_spectag == prtag);
      end else begin
        {ent_v1[i], ent_src1[i]} <= snoop(ent_v1[i], ent_src1[i]);
        {ent_v2[i], ent_src2[i]} <= snoop(ent_v2[i], ent_src2[i]);
        if (prsuccess && ent_spectag[i] == prtag) ent_specbit[i] <= 1'b0;
      end
    end
  end

  // A dispatch attempt while full is dropped by the station; flag it in simulation.
  assert property (@(posedge clk) disable iff (reset) !(dp_we && full))
    else $warning("rs_custom: dispatch while full was ignored");

endmodule

// File: tb/tb_rs_custom.sv
// Scoreboard bench for rs_custom: the driver pushes the expected issue
// (cycle and payload) when it applies stimulus; a negedge monitor pops and
// compares every time the station asserts issue.
module tb_rs_custom;

  logic        clk = 1'b0;
  logic        reset;
  logic        dp_we;
  logic [31:0] dp_src1, dp_src2, dp_imm;
  logic        dp_valid1, dp_valid2;
  logic [5:0]  dp_rrftag;
  logic        dp_dstval;
  logic [2:0]  dp_funct3;
  logic [6:0]  dp_funct7;
  logic [4:0]  dp_spectag;
  logic        dp_specbit;
  logic        wb_val0, wb_val1;
  logic [5:0]  wb_tag0, wb_tag1;
  logic [31:0] wb_data0, wb_data1;
  logic        prmiss, prsuccess;
  logic [4:0]  killmask, prtag;
  logic        full;
  logic [2:0]  busy_cnt;
  logic        issue;
  logic [31:0] ex_src1, ex_src2, ex_imm;
  logic [5:0]  ex_rrftag;
  logic        ex_dstval;
  logic [2:0]  ex_funct3;
  logic [6:0]  ex_funct7;
  logic [4:0]  ex_spectag;
  logic        ex_specbit;

  rs_custom dut (
    .clk(clk), .reset(reset), .dp_we(dp_we),
    .dp_src1(dp_src1), .dp_src2(dp_src2),
    .dp_valid1(dp_valid1), .dp_valid2(dp_valid2),
    .dp_imm(dp_imm), .dp_rrftag(dp_rrftag), .dp_dstval(dp_dstval),
    .dp_funct3(dp_funct3), .dp_funct7(dp_funct7),
    .dp_spectag(dp_spectag), .dp_specbit(dp_specbit),
    .wb_val0(wb_val0), .wb_val1(wb_val1),
    .wb_tag0(wb_tag0), .wb_tag1(wb_tag1),
    .wb_data0(wb_data0), .wb_data1(wb_data1),
    .prmiss(prmiss), .killmask(killmask),
    .prsuccess(prsuccess), .prtag(prtag),
    .full(full), .busy_cnt(busy_cnt), .issue(issue),
    .ex_src1(ex_src1), .ex_src2(ex_src2), .ex_imm(ex_imm),
    .ex_rrftag(ex_rrftag), .ex_dstval(ex_dstval),
    .ex_funct3(ex_funct3), .ex_funct7(ex_funct7),
    .ex_spectag(ex_spectag), .ex_specbit(ex_specbit)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    int unsigned cyc;
    logic [31:0] s1;
    logic [31:0] s2;
    logic [2:0]  f3;
    logic [5:0]  tag;
    logic        sb;
  } exp_t;

  exp_t        expq[$];
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  logic        mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every issue must match the oldest expected entry, cycle included.
  always @(negedge clk) begin
    exp_t e, a;
    if (mon_en && issue) begin
      checks++;
      a = '{cyc: cyc, s1: ex_src1, s2: ex_src2, f3: ex_funct3, tag: ex_rrftag, sb: ex_specbit};
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: cycle %0d tag %h issued, required no issue", cyc, ex_rrftag);
      end else begin
        e = expq.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL issue_payload: got cyc=%0d s1=%h s2=%h f3=%0d tag=%h sb=%b, required cyc=%0d s1=%h s2=%h f3=%0d tag=%h sb=%b",
                   a.cyc, a.s1, a.s2, a.f3, a.tag, a.sb, e.cyc, e.s1, e.s2, e.f3, e.tag, e.sb);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    reset = 1'b0; dp_we = 1'b0; wb_val0 = 1'b0; wb_val1 = 1'b0;
    prmiss = 1'b0; prsuccess = 1'b0;
  endtask

  task automatic disp(input logic [31:0] s1, input logic [31:0] s2, input logic v1,
                      input logic v2, input logic [2:0] f3, input logic [5:0] tag,
                      input logic [4:0] st, input logic sb);
    dp_we = 1'b1; dp_src1 = s1; dp_src2 = s2; dp_valid1 = v1; dp_valid2 = v2;
    dp_funct3 = f3; dp_rrftag = tag; dp_spectag = st; dp_specbit = sb;
    dp_imm = s1 ^ s2; dp_funct7 = {1'b0, tag}; dp_dstval = 1'b1;
  endtask

  task automatic bcast(input int bus, input logic [5:0] tag, input logic [31:0] d);
    if (bus == 0) begin wb_val0 = 1'b1; wb_tag0 = tag; wb_data0 = d; end
    else          begin wb_val1 = 1'b1; wb_tag1 = tag; wb_data1 = d; end
  endtask

  task automatic push(input int unsigned c, input logic [31:0] s1, input logic [31:0] s2,
                      input logic [2:0] f3, input logic [5:0] tag, input logic sb);
    expq.push_back('{cyc: c, s1: s1, s2: s2, f3: f3, tag: tag, sb: sb});
  endtask

  initial begin
    reset = 1'b1; dp_we = 1'b0; wb_val0 = 1'b0; wb_val1 = 1'b0;
    prmiss = 1'b0; prsuccess = 1'b0; killmask = '0; prtag = '0;
    dp_src1 = '0; dp_src2 = '0; dp_valid1 = 1'b0; dp_valid2 = 1'b0; dp_imm = '0;
    dp_rrftag = '0; dp_dstval = 1'b0; dp_funct3 = '0; dp_funct7 = '0;
    dp_spectag = '0; dp_specbit = 1'b0;
    wb_tag0 = '0; wb_tag1 = '0; wb_data0 = '0; wb_data1 = '0;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    mon_en = 1'b1;
    check("reset_full", 32'(full), 32'd0);
    check("reset_busy", 32'(busy_cnt), 32'd0);
    check("reset_issue", 32'(issue), 32'd0);

    // Both operands valid at dispatch: issue the next cycle.
    disp(32'h10, 32'h20, 1, 1, 3'd3, 6'h01, 5'b0, 0);
    push(cyc + 1, 32'h10, 32'h20, 3'd3, 6'h01, 0);
    tick;
    check("t1_busy_during", 32'(busy_cnt), 32'd1);
    tick;
    check("t1_busy_after", 32'(busy_cnt), 32'd0);

    // Wakeup two cycles after dispatch on bus 0.
    disp(32'h5, 32'h22, 0, 1, 3'd1, 6'h02, 5'b0, 0);
    tick; tick;
    bcast(0, 6'h05, 32'hDEAD);
    push(cyc + 1, 32'hDEAD, 32'h22, 3'd1, 6'h02, 0);
    tick; tick;
    // Same-cycle snoop at dispatch on bus 1.
    disp(32'h7, 32'h33, 0, 1, 3'd2, 6'h03, 5'b0, 0);
    bcast(1, 6'h07, 32'hBEEF);
    push(cyc + 1, 32'hBEEF, 32'h33, 3'd2, 6'h03, 0);
    tick; tick;
    // Both buses carry the same tag: bus 0 data wins.
    disp(32'h44, 32'h9, 1, 0, 3'd4, 6'h04, 5'b0, 0);
    tick;
    bcast(0, 6'h09, 32'h1111);
    bcast(1, 6'h09, 32'h2222);
    push(cyc + 1, 32'h44, 32'h1111, 3'd4, 6'h04, 0);
    tick; tick;
    check("t2_busy_drained", 32'(busy_cnt), 32'd0);

    // Fill all four entries with unready ops.
    for (int k = 0; k < 4; k++) begin
      disp(32'h10 + 32'(k), 32'h50 + 32'(k), 0, 1, 3'd5, 6'h10 + 6'(k), 5'b0, 0);
      tick;
    end
    check("t3_full", 32'(full), 32'd1);
    check("t3_busy4", 32'(busy_cnt), 32'd4);
    disp(32'h14, 32'h54, 1, 1, 3'd5, 6'h14, 5'b0, 0);
    tick;
    check("t3_busy_after_extra", 32'(busy_cnt), 32'd4);
    bcast(0, 6'h12, 32'h1234);
    push(cyc + 1, 32'h1234, 32'h52, 3'd5, 6'h12, 0);
    tick;
    check("t3_full_while_issuing", 32'(full), 32'd1);
    tick;
    check("t3_full_cleared", 32'(full), 32'd0);
    check("t3_busy3", 32'(busy_cnt), 32'd3);
    bcast(0, 6'h10, 32'hA0);
    bcast(1, 6'h11, 32'hA1);
    push(cyc + 1, 32'hA0, 32'h50, 3'd5, 6'h10, 0);
    push(cyc + 2, 32'hA1, 32'h51, 3'd5, 6'h11, 0);
    tick;
    bcast(0, 6'h13, 32'hA3);
    push(cyc + 2, 32'hA3, 32'h53, 3'd5, 6'h13, 0);
    tick; tick; tick;
    check("t3_busy_drained", 32'(busy_cnt), 32'd0);

    // Mispredict kills two speculative entries, including the selected one.
    disp(32'h20, 32'h60, 0, 1, 3'd6, 6'h20, 5'b00010, 1);
    tick;
    disp(32'h21, 32'h61, 0, 1, 3'd6, 6'h21, 5'b00000, 0);
    tick;
    disp(32'h62, 32'h63, 1, 1, 3'd6, 6'h22, 5'b00100, 1);
    tick;
    prmiss = 1'b1; killmask = 5'b00110;
    #1;
    check("t4_issue_suppressed", 32'(issue), 32'd0);
    tick;
    check("t4_busy1", 32'(busy_cnt), 32'd1);
    bcast(0, 6'h21, 32'hC1);
    bcast(1, 6'h20, 32'hC0);
    push(cyc + 1, 32'hC1, 32'h61, 3'd6, 6'h21, 0);
    tick; tick;
    check("t4_busy_drained", 32'(busy_cnt), 32'd0);

    // Correct prediction clears specbit, for a held entry and a same-cycle dispatch.
    disp(32'h30, 32'h70, 0, 1, 3'd7, 6'h30, 5'b01000, 1);
    tick;
    disp(32'h31, 32'h71, 0, 1, 3'd7, 6'h31, 5'b01000, 1);
    prsuccess = 1'b1; prtag = 5'b01000;
    tick;
    prmiss = 1'b1; killmask = 5'b01000;
    tick;
    check("t5_busy_survive", 32'(busy_cnt), 32'd2);
    bcast(0, 6'h30, 32'hD0);
    bcast(1, 6'h31, 32'hD1);
    push(cyc + 1, 32'hD0, 32'h70, 3'd7, 6'h30, 0);
    push(cyc + 2, 32'hD1, 32'h71, 3'd7, 6'h31, 0);
    tick; tick; tick;
    // Issuing entry shows its pre-clear specbit.
    disp(32'h80, 32'h81, 1, 1, 3'd1, 6'h35, 5'b10000, 1);
    push(cyc + 1, 32'h80, 32'h81, 3'd1, 6'h35, 1);
    tick;
    prsuccess = 1'b1; prtag = 5'b10000;
    tick; tick;

    // Reset with three entries held and a dispatch in the same cycle.
    for (int k = 0; k < 3; k++) begin
      disp(32'h40 + 32'(k), 32'h90, 0, 1, 3'd2, 6'h40 + 6'(k), 5'b0, 0);
      tick;
    end
    check("t6_busy3", 32'(busy_cnt), 32'd3);
    reset = 1'b1;
    disp(32'h91, 32'h92, 1, 1, 3'd2, 6'h3F, 5'b0, 0);
    tick;
    check("t6_busy0", 32'(busy_cnt), 32'd0);
    check("t6_full0", 32'(full), 32'd0);
    check("t6_issue0", 32'(issue), 32'd0);
    bcast(0, 6'h40, 32'hE0);
    tick; tick; tick;

    check("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
